// File: rtl/ex_1_pkg.sv
// ex_1_pkg: shared definitions for the ex_1 divisibility classifier.
//   DIV2_IDX/DIV3_IDX/DIV6_IDX : bit positions of the flags inside divs
//   CNT_W / CNT_MAX            : hit-counter width and saturation value
//   pair_weight_sum()          : alternating bit-pair weighted sum (mod-3 preserving)
package ex_1_pkg;

    localparam int unsigned DIV2_IDX = 2;
    localparam int unsigned DIV3_IDX = 1;
    localparam int unsigned DIV6_IDX = 0;

    localparam int unsigned           CNT_W   = 8;
    localparam logic [CNT_W-1:0]      CNT_MAX = '1;

    // 2^k mod 3 is 1 for even k and 2 for odd k, so this sum has the same
    // residue modulo 3 as v. Max result for a 32-bit word is 48.
    function automatic logic [7:0] pair_weight_sum(input logic [31:0] v);
        logic [7:0] s;
        s = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v[i]) begin
                if (i[0]) s = s + 8'd2;
                else      s = s + 8'd1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/ex_1_if.sv
// ex_1_if: data bundle between a producer and the ex_1 classifier.
//   in      : unsigned operand (WIDTH bits), driven by master
//   divs    : {by2, by3, by6} registered flags, driven by slave
//   cnt_by* : 8-bit saturating hit counters (only with EX_1_HIT_CNT_EN)
// Macro: EX_1_HIT_CNT_EN adds the counter signals.
interface ex_1_if #(
    parameter int unsigned WIDTH = 4
);
    import ex_1_pkg::*;

    logic [WIDTH-1:0] in;
    logic [2:0]       divs;
`ifdef EX_1_HIT_CNT_EN
    logic [CNT_W-1:0] cnt_by2;
    logic [CNT_W-1:0] cnt_by3;
    logic [CNT_W-1:0] cnt_by6;

    modport master (output in, input divs, input cnt_by2, input cnt_by3, input cnt_by6);
    modport slave  (input in, output divs, output cnt_by2, output cnt_by3, output cnt_by6);
`else
    modport master (output in, input divs);
    modport slave  (input in, output divs);
`endif

endinterface

// File: rtl/ex_1_mod3_residue.sv
// mod3_residue: purely combinational residue of an unsigned word modulo 3,
// without a divider.
//   in_i       : unsigned operand, WIDTH bits (2..32)
//   residue_o  : in_i mod 3, in 0..2
module mod3_residue
    import ex_1_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [1:0]       residue_o
);

    logic [31:0] ext;
    logic [7:0]  s0;
    logic [7:0]  s1;
    logic [7:0]  s2;
    logic [7:0]  r;

    // Three folds shrink the sum: <=48, then <=9, then <=4; two
    // conditional subtractions finish the reduction into 0..2.
    always_comb begin
        ext            = '0;
        ext[WIDTH-1:0] = in_i;
        s0 = pair_weight_sum(ext);
        s1 = pair_weight_sum({24'b0, s0});
        s2 = pair_weight_sum({24'b0, s1});
        r  = s2;
        if (r >= 8'd6) r = r - 8'd6;
        if (r >= 8'd3) r = r - 8'd3;
        residue_o = r[1:0];
    end

endmodule

// File: rtl/ex_1.sv
// ex_1: registered divisibility classifier.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears all outputs)
//   bus   : ex_1_if.slave -- in (operand), divs = {by2, by3, by6} one cycle
//           after sampling; cnt_by2/3/6 saturating hit counters when
//           EX_1_HIT_CNT_EN is defined.
// Macro: EX_1_HIT_CNT_EN enables the hit counters.
module ex_1
    import ex_1_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    ex_1_if.slave bus
);

    logic [WIDTH-1:0] in_w;
    logic [1:0]       residue;
    logic             by2;
    logic             by3;
    logic             by6;
    logic [2:0]       divs_d;
    logic [2:0]       divs_q;

    assign in_w = bus.in;

    mod3_residue #(
        .WIDTH(WIDTH)
    ) u_mod3 (
        .in_i      (in_w),
        .residue_o (residue)
    );

    always_comb begin
        by2    = ~in_w[0];
        by3    = (residue == 2'd0);
        by6    = by2 & by3;
        divs_d = '0;
        divs_d[DIV2_IDX] = by2;
        divs_d[DIV3_IDX] = by3;
        divs_d[DIV6_IDX] = by6;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) divs_q <= '0;
        else        divs_q <= divs_d;
    end

    assign bus.divs = divs_q;

`ifdef EX_1_HIT_CNT_EN
    logic [CNT_W-1:0] cnt_by2_q, cnt_by2_d;
    logic [CNT_W-1:0] cnt_by3_q, cnt_by3_d;
    logic [CNT_W-1:0] cnt_by6_q, cnt_by6_d;

    // Each counter sticks at CNT_MAX until reset.
    always_comb begin
        cnt_by2_d = cnt_by2_q;
        cnt_by3_d = cnt_by3_q;
        cnt_by6_d = cnt_by6_q;
        if (by2 && (cnt_by2_q != CNT_MAX)) cnt_by2_d = cnt_by2_q + 1'b1;
        if (by3 && (cnt_by3_q != CNT_MAX)) cnt_by3_d = cnt_by3_q + 1'b1;
        if (by6 && (cnt_by6_q != CNT_MAX)) cnt_by6_d = cnt_by6_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_by2_q <= '0;
            cnt_by3_q <= '0;
            cnt_by6_q <= '0;
        end else begin
            cnt_by2_q <= cnt_by2_d;
            cnt_by3_q <= cnt_by3_d;
            cnt_by6_q <= cnt_by6_d;
        end
    end

    assign bus.cnt_by2 = cnt_by2_q;
    assign bus.cnt_by3 = cnt_by3_q;
    assign bus.cnt_by6 = cnt_by6_q;
`endif

endmodule

// File: tb/tb_ex_1.sv
// tb_ex_1: directed self-checking bench for ex_1 (WIDTH=4 and WIDTH=8 instances).
// Macro: EX_1_HIT_CNT_EN additionally exercises the hit counters.
module tb_ex_1;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    ex_1_if #(.WIDTH(4)) bus4 ();
    ex_1_if #(.WIDTH(8)) bus8 ();

    ex_1 #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    ex_1 #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n   = 1'b0;
        bus4.in = 4'b0000;
        bus8.in = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (bus4.divs !== 3'b000)
            $display("FAIL reset_divs: got %b expected %b", bus4.divs, 3'b000);
        else pass_cnt++;
`ifdef EX_1_HIT_CNT_EN
        total_cnt++;
        if ({bus4.cnt_by2, bus4.cnt_by3, bus4.cnt_by6} !== 24'h0)
            $display("FAIL reset_cnt: got %h expected %h",
                     {bus4.cnt_by2, bus4.cnt_by3, bus4.cnt_by6}, 24'h0);
        else pass_cnt++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus4.divs !== 3'b111)
            $display("FAIL reset_release: got %b expected %b", bus4.divs, 3'b111);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        logic [2:0] exp_tab [16];
        exp_tab = '{3'b111, 3'b000, 3'b100, 3'b010, 3'b100, 3'b000, 3'b111, 3'b000,
                    3'b100, 3'b010, 3'b100, 3'b000, 3'b111, 3'b000, 3'b100, 3'b010};
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            bus4.in = 4'(v);
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus4.divs !== exp_tab[v])
                $display("FAIL sweep_in%0d: got %b expected %b", v, bus4.divs, exp_tab[v]);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus4.in = 4'b0110;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus4.divs !== 3'b111)
            $display("FAIL async_pre: got %b expected %b", bus4.divs, 3'b111);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus4.divs !== 3'b000)
            $display("FAIL async_assert: got %b expected %b", bus4.divs, 3'b000);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus4.divs !== 3'b000)
            $display("FAIL async_hold: got %b expected %b", bus4.divs, 3'b000);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus4.divs !== 3'b111)
            $display("FAIL async_release: got %b expected %b", bus4.divs, 3'b111);
        else pass_cnt++;
    endtask

    task automatic test_width8();
        logic [7:0] vin  [6];
        logic [2:0] vexp [6];
        vin  = '{8'd255, 8'd252, 8'd254, 8'd0, 8'd129, 8'd170};
        vexp = '{3'b010, 3'b111, 3'b100, 3'b111, 3'b010, 3'b100};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus8.in = vin[i];
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus8.divs !== vexp[i])
                $display("FAIL w8_in%0d: got %b expected %b", vin[i], bus8.divs, vexp[i]);
            else pass_cnt++;
        end
    endtask

`ifdef EX_1_HIT_CNT_EN
    task automatic test_counters();
        @(negedge clk);
        rst_n   = 1'b0;
        bus4.in = 4'b0010;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({bus4.cnt_by2, bus4.cnt_by3, bus4.cnt_by6} !== {8'd1, 8'd0, 8'd0})
            $display("FAIL cnt_by2_only: got %h expected %h",
                     {bus4.cnt_by2, bus4.cnt_by3, bus4.cnt_by6}, {8'd1, 8'd0, 8'd0});
        else pass_cnt++;
        @(negedge clk);
        bus4.in = 4'b0110;
        repeat (10) @(posedge clk);
        #1;
        total_cnt++;
        if ({bus4.cnt_by2, bus4.cnt_by3, bus4.cnt_by6} !== {8'd11, 8'd10, 8'd10})
            $display("FAIL cnt_ten: got %h expected %h",
                     {bus4.cnt_by2, bus4.cnt_by3, bus4.cnt_by6}, {8'd11, 8'd10, 8'd10});
        else pass_cnt++;
        repeat (290) @(posedge clk);
        #1;
        total_cnt++;
        if ({bus4.cnt_by2, bus4.cnt_by3, bus4.cnt_by6} !== 24'hFFFFFF)
            $display("FAIL cnt_sat: got %h expected %h",
                     {bus4.cnt_by2, bus4.cnt_by3, bus4.cnt_by6}, 24'hFFFFFF);
        else pass_cnt++;
        @(negedge clk);
        bus4.in = 4'b0001;
        repeat (5) @(posedge clk);
        #1;
        total_cnt++;
        if ({bus4.cnt_by2, bus4.cnt_by3, bus4.cnt_by6} !== 24'hFFFFFF)
            $display("FAIL cnt_hold: got %h expected %h",
                     {bus4.cnt_by2, bus4.cnt_by3, bus4.cnt_by6}, 24'hFFFFFF);
        else pass_cnt++;
    endtask
`endif

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        bus4.in   = '0;
        bus8.in   = '0;
        test_reset();
        test_sweep();
        test_async_reset();
        test_width8();
`ifdef EX_1_HIT_CNT_EN
        test_counters();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ex_1.md
# ex_1

Registered divisibility classifier: each cycle it samples an unsigned input word and flags whether the value is divisible by 2, by 3 and by 6. It is a small leaf block used by arithmetic and filtering stages that need cheap divisibility hints without a divider. All flags come from registers, one clock after sampling.

## Interface
- WIDTH, default 4: width of the unsigned input word; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  unsigned operand, sampled on every rising edge of clk.
- divs  output  3  registered flags:
  - divs[2]: in divisible by 2.
  - divs[1]: in divisible by 3.
  - divs[0]: in divisible by 6.
- cnt_by2, cnt_by3, cnt_by6  output  8 each  saturating hit counters; present only with EX_1_HIT_CNT_EN.

## Operation
- by2 = ~in[0].
- by3: residue of in modulo 3 from the alternating bit-pair sum (even-index bits weigh 1, odd-index bits weigh 2), folded down to 0..2; by3 = (residue == 0).
- No divider and no `%` operator is used.
- by6 = by2 & by3.
- Zero is divisible by all three: in = 0 gives divs = 3'b111.
- Input is always treated as unsigned; there are no invalid input codes.
- divs = {by2, by3, by6}, registered.

## Timing
- Latency 1 cycle: divs after rising edge N reflects in sampled at edge N.
- New result every cycle; no handshake and no stall.
- Reset value: divs = 3'b000 (all flags low, including before the first sample), and counters = 0.
- rst_n assertion clears all outputs immediately, asynchronous to clk.
- Deassertion takes effect at the next rising edge.
- The first valid result appears one edge after deassertion.
- Reset asserted mid-stream discards the pending result; no partial state survives.

## Configuration
- Macro: EX_1_HIT_CNT_EN.
- Defined:
  - Adds cnt_by2, cnt_by3 and cnt_by6.
  - Each counter increments by 1 on every rising edge where the corresponding by2/by3/by6 flag computed from the sampled in is 1.
  - Counters saturate at 8'hFF and hold there until reset.
  - The counters update on the same edge as divs.
- Undefined: the counter ports and logic are absent. divs behaviour is identical in both builds.

## Structure
- Shared package ex_1_pkg holds:
  - flag index constants DIV2_IDX = 2, DIV3_IDX = 1, DIV6_IDX = 0;
  - counter width CNT_W = 8 and saturation value CNT_MAX.
- One sub-module, mod3_residue:
  - Parameterised by WIDTH.
  - Purely combinational, in to residue[1:0].
  - Reusable by other blocks.
- Top level holds the flag logic, the output register and the optional counters.

## Test plan
- Reset: hold rst_n = 0 with in = 4'b0000 -> divs = 3'b000. Release, drive 4'b0000 -> divs = 3'b111 after one edge.
- Sweep in = 0..11, one per cycle. Required divs per value, 0 to 11: 111, 000, 100, 010, 100, 000, 111, 000, 100, 010, 100, 000 (each one cycle late).
- Values 12..15 -> 111, 000, 100, 010, confirming full 4-bit coverage.
- Assert rst_n asynchronously between edges while in = 4'b0110 -> divs drops to 000 without waiting for clk. After release it returns to 111.
- WIDTH = 8, in = 8'd255 -> divs = 3'b010. in = 8'd252 -> 3'b111. in = 8'd254 -> 3'b100.
- With EX_1_HIT_CNT_EN, hold in = 4'b0110 for 300 cycles -> all three counters = 8'hFF and stay there. Then hold in = 4'b0001 -> counters do not change.
